// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the 8N1 UART receiver and transmitter.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 5208;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset value.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic srst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            ff_q <= {2{RESET_VAL}};
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises rx, finds the start bit, samples each bit at its
// mid-point (LSB first) and reports good bytes with valid or bad stop bits with frame_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  SYNC_FILL = CNT_W'(2);
    localparam logic [2:0]        IDX_LAST  = 3'(DATA_BITS - 1);

    logic rx_s;

    uart_state_t            state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [2:0]             idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   ferr_q;
    logic                   busy_q;

    sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk  (sysclk),
        .srst (reset),
        .d_i  (rx),
        .q_o  (rx_s)
    );

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= ST_WAIT_HIGH;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            cnt_q   <= cnt_q + CNT_ONE;
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DATA;
                            idx_q   <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        if (idx_q == IDX_LAST) begin
                            state_q <= ST_STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= ST_WAIT_HIGH;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    // After reset the synchroniser still holds its idle value for two
                    // clocks; wait for it to reflect the real line before trusting a high.
                    if (rx_s && (cnt_q >= SYNC_FILL)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_WAIT_HIGH;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule
